// File: rtl/fractal_sync_cc.sv
// fractal_sync_cc: issues one core barrier request as a fractal sync pulse and returns wake/error/timeout outcome
module fractal_sync_cc #(
  parameter int LVL_WIDTH      = 2,
  parameter int LVL_OFFSET     = 1,
  parameter int ID_WIDTH       = 2,
  parameter int ID_OFFSET      = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES+1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [LVL_WIDTH-1:0]            req_level_i,
  input  logic [ID_WIDTH-1:0]             req_id_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [1:0]                      rsp_status_o,
  output logic [LVL_WIDTH-LVL_OFFSET-1:0] rsp_level_o,
  output logic [ID_WIDTH+ID_OFFSET-1:0]   rsp_id_o,
  output logic                            sync_o,
  output logic [LVL_WIDTH-1:0]            level_o,
  output logic [ID_WIDTH-1:0]             id_o,
  input  logic                            wake_i,
  input  logic [LVL_WIDTH-LVL_OFFSET-1:0] level_i,
  input  logic [ID_WIDTH+ID_OFFSET-1:0]   id_i,
  input  logic                            error_i,
  output logic                            spurious_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SYNC = 2'd1, S_WAIT = 2'd2, S_RSP = 2'd3;
  localparam int CW = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  logic [1:0]                      r_state;
  logic [CW-1:0]                   r_cnt;
  logic [1:0]                      r_status;
  logic [LVL_WIDTH-LVL_OFFSET-1:0] r_rsp_level;
  logic [ID_WIDTH+ID_OFFSET-1:0]   r_rsp_id;
  logic [LVL_WIDTH-1:0]            r_level;
  logic [ID_WIDTH-1:0]             r_id;
  logic                            r_spurious;
  logic                            w_hit;
  logic                            w_tmo;
  assign w_hit = wake_i | error_i;
  assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign req_ready_o  = (r_state == S_IDLE);
  assign rsp_valid_o  = (r_state == S_RSP);
  assign sync_o       = (r_state == S_SYNC);
  assign rsp_status_o = r_status;
  assign rsp_level_o  = r_rsp_level;
  assign rsp_id_o     = r_rsp_id;
  assign level_o      = r_level;
  assign id_o         = r_id;
  assign spurious_o   = r_spurious;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_status    <= '0;
      r_rsp_level <= '0;
      r_rsp_id    <= '0;
      r_level     <= '0;
      r_id        <= '0;
      r_spurious  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE || r_state == S_RSP) && w_hit) r_spurious <= 1'b1;
      case (r_state)
        S_IDLE: if (req_valid_i) begin
          r_level <= req_level_i;
          r_id    <= req_id_i;
          if (req_level_i == '0) begin
            r_state     <= S_RSP;
            r_status    <= 2'b11;
            r_rsp_level <= '0;
            r_rsp_id    <= '0;
          end else r_state <= S_SYNC;
        end
        S_SYNC: begin
          r_cnt <= '0;
          r_state <= w_hit ? S_RSP : S_WAIT;
          if (w_hit) begin
            r_status    <= error_i ? 2'b01 : 2'b00;
            r_rsp_level <= level_i;
            r_rsp_id    <= id_i;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_hit) begin
            r_state     <= S_RSP;
            r_status    <= error_i ? 2'b01 : 2'b00;
            r_rsp_level <= level_i;
            r_rsp_id    <= id_i;
          end else if (w_tmo) begin
            r_state     <= S_RSP;
            r_status    <= 2'b10;
            r_rsp_level <= '0;
            r_rsp_id    <= '0;
          end
        end
        default: if (rsp_ready_i) r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fractal_sync_cc.sv
// tb_fractal_sync_cc: directed checks of handshake, wake, error priority, timeout, bad level, spurious and reset
module tb_fractal_sync_cc;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [1:0] req_level_i = '0;
  logic [1:0] req_id_i = '0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [1:0] rsp_status_o;
  logic [0:0] rsp_level_o;
  logic [2:0] rsp_id_o;
  logic       sync_o;
  logic [1:0] level_o;
  logic [1:0] id_o;
  logic       wake_i = 1'b0;
  logic [0:0] level_i = '0;
  logic [2:0] id_i = '0;
  logic       error_i = 1'b0;
  logic       spurious_o;
  int checks = 0;
  int errors = 0;

  fractal_sync_cc #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_level_i(req_level_i), .req_id_i(req_id_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_status_o(rsp_status_o), .rsp_level_o(rsp_level_o), .rsp_id_o(rsp_id_o),
    .sync_o(sync_o), .level_o(level_o), .id_o(id_o),
    .wake_i(wake_i), .level_i(level_i), .id_i(id_i), .error_i(error_i),
    .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_req_ready", 32'(req_ready_o), 1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_status", 32'(rsp_status_o), 0);
    chk("rst_rsp_level", 32'(rsp_level_o), 0);
    chk("rst_rsp_id", 32'(rsp_id_o), 0);
    chk("rst_sync", 32'(sync_o), 0);
    chk("rst_level_o", 32'(level_o), 0);
    chk("rst_id_o", 32'(id_o), 0);
    chk("rst_spurious", 32'(spurious_o), 0);
    rst_ni = 1'b1;
    step();
    // wake three cycles after sync
    req_valid_i = 1'b1; req_level_i = 2'd1; req_id_i = 2'd2;
    step();
    req_valid_i = 1'b0;
    chk("t1_sync_hi", 32'(sync_o), 1);
    chk("t1_level_o", 32'(level_o), 1);
    chk("t1_id_o", 32'(id_o), 2);
    chk("t1_ready_lo", 32'(req_ready_o), 0);
    step();
    chk("t1_sync_one_cycle", 32'(sync_o), 0);
    step();
    step();
    chk("t1_no_rsp_yet", 32'(rsp_valid_o), 0);
    wake_i = 1'b1; level_i = 1'b1; id_i = 3'd5;
    step();
    wake_i = 1'b0; level_i = '0; id_i = '0;
    chk("t1_rsp_valid", 32'(rsp_valid_o), 1);
    chk("t1_status", 32'(rsp_status_o), 0);
    chk("t1_rsp_level", 32'(rsp_level_o), 1);
    chk("t1_rsp_id", 32'(rsp_id_o), 5);
    chk("t1_no_spurious", 32'(spurious_o), 0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("t1_idle_ready", 32'(req_ready_o), 1);
    chk("t1_idle_rsp_lo", 32'(rsp_valid_o), 0);
    // level 0 is rejected without a sync
    req_valid_i = 1'b1; req_level_i = 2'd0; req_id_i = 2'd3;
    step();
    req_valid_i = 1'b0;
    chk("t2_no_sync", 32'(sync_o), 0);
    chk("t2_rsp_valid", 32'(rsp_valid_o), 1);
    chk("t2_status", 32'(rsp_status_o), 3);
    chk("t2_rsp_level", 32'(rsp_level_o), 0);
    chk("t2_rsp_id", 32'(rsp_id_o), 0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    // timeout of 8: response 9 cycles after sync
    req_valid_i = 1'b1; req_level_i = 2'd2; req_id_i = 2'd1;
    step();
    req_valid_i = 1'b0;
    chk("t3_sync_hi", 32'(sync_o), 1);
    for (int i = 0; i < 8; i++) step();
    chk("t3_not_early", 32'(rsp_valid_o), 0);
    step();
    chk("t3_rsp_valid", 32'(rsp_valid_o), 1);
    chk("t3_status", 32'(rsp_status_o), 2);
    chk("t3_rsp_level", 32'(rsp_level_o), 0);
    chk("t3_rsp_id", 32'(rsp_id_o), 0);
    chk("t3_level_o_held", 32'(level_o), 2);
    chk("t3_id_o_held", 32'(id_o), 1);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    // error beats wake
    req_valid_i = 1'b1; req_level_i = 2'd3; req_id_i = 2'd0;
    step();
    req_valid_i = 1'b0;
    step();
    wake_i = 1'b1; error_i = 1'b1; level_i = 1'b0; id_i = 3'd7;
    step();
    wake_i = 1'b0; error_i = 1'b0; id_i = '0;
    chk("t4_rsp_valid", 32'(rsp_valid_o), 1);
    chk("t4_status", 32'(rsp_status_o), 1);
    chk("t4_rsp_id", 32'(rsp_id_o), 7);
    // stalled response with spurious wakes
    for (int i = 0; i < 5; i++) begin
      wake_i = (i % 2 == 0); level_i = 1'b1; id_i = 3'd2;
      step();
    end
    wake_i = 1'b0; level_i = '0; id_i = '0;
    chk("t5_rsp_valid_held", 32'(rsp_valid_o), 1);
    chk("t5_status_held", 32'(rsp_status_o), 1);
    chk("t5_rsp_level_held", 32'(rsp_level_o), 0);
    chk("t5_rsp_id_held", 32'(rsp_id_o), 7);
    chk("t5_spurious", 32'(spurious_o), 1);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    // reset during WAIT, late wake is spurious
    req_valid_i = 1'b1; req_level_i = 2'd1; req_id_i = 2'd1;
    step();
    req_valid_i = 1'b0;
    step();
    rst_ni = 1'b0;
    step();
    chk("t6_rst_ready", 32'(req_ready_o), 1);
    chk("t6_rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("t6_rst_status", 32'(rsp_status_o), 0);
    chk("t6_rst_sync", 32'(sync_o), 0);
    chk("t6_rst_level_o", 32'(level_o), 0);
    chk("t6_rst_id_o", 32'(id_o), 0);
    chk("t6_rst_spurious", 32'(spurious_o), 0);
    rst_ni = 1'b1; wake_i = 1'b1;
    step();
    wake_i = 1'b0;
    chk("t6_spurious", 32'(spurious_o), 1);
    chk("t6_rsp_valid_lo", 32'(rsp_valid_o), 0);
    chk("t6_ready", 32'(req_ready_o), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
